// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//   DATA_WIDTH_DEF : default activation width.
//   cnt_width()    : $clog2-based counter width, never narrower than 1 bit.
//   COL_W_DEF /
//   ROW_W_DEF      : counter widths for the default 8x8 feature map.
//   max2()         : signed maximum on MAX2_W-bit operands. Narrower callers
//                    sign-extend into it and truncate the result.
package cnn_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int IMG_DIM_DEF    = 8;
  localparam int MAX2_W         = 32;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF = cnt_width(IMG_DIM_DEF);
  localparam int ROW_W_DEF = cnt_width(IMG_DIM_DEF);

  // Ties return the common value, so the >= / > choice does not matter.
  function automatic logic signed [MAX2_W-1:0] max2(
    input logic signed [MAX2_W-1:0] a,
    input logic signed [MAX2_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// Half-row line buffer for the 2x2 max-pool stage.
// Holds one horizontal-pair maximum per pooled column of the last even row.
// Contents are not reset: every entry is written on an even row before the
// following odd row reads it.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write index (col>>1)
//   wr_data : pair maximum to store
//   rd_addr : asynchronous read index (col>>1)
//   rd_data : stored pair maximum
module maxpool_line_buffer
  import cnn_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int depth      = 4,
  parameter int addr_w     = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [addr_w-1:0]     wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic [addr_w-1:0]     rd_addr,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read, which lets this map onto distributed RAM.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool stage.
// Takes one signed activation per accepted cycle in row-major order and
// emits one pooled maximum per 2x2 window, also in row-major order.
//   clk        : clock
//   reset      : asynchronous active-high reset
//   in_valid   : input sample present
//   in_ready   : stage can take a sample (!out_valid || out_ready)
//   in         : signed activation
//   out_valid  : pooled result present
//   out_ready  : consumer takes the result
//   out        : signed pooled maximum
//   frame_done : high in the cycle the last result of a frame is consumed
module maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int img_width  = 8,
  parameter int img_height = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out,
  output logic                  frame_done
);

  localparam int COL_W    = cnt_width(img_width);
  localparam int ROW_W    = cnt_width(img_height);
  localparam int LB_DEPTH = img_width / 2;
  localparam int ADDR_W   = cnt_width(LB_DEPTH);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(img_width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(img_height - 1);

  function automatic logic signed [data_width-1:0] smax(
    input logic signed [data_width-1:0] a,
    input logic signed [data_width-1:0] b
  );
    logic signed [MAX2_W-1:0] r;
    r = max2(MAX2_W'(a), MAX2_W'(b));
    return r[data_width-1:0];
  endfunction

  logic [COL_W-1:0]              col_q, col_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic signed [data_width-1:0]  pair_q, pair_d;
  logic signed [data_width-1:0]  out_q, out_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;

  logic signed [data_width-1:0]  in_s;
  logic signed [data_width-1:0]  hmax;
  logic signed [data_width-1:0]  pooled;
  logic [data_width-1:0]         lb_rd;
  logic [ADDR_W-1:0]             lb_addr;
  logic                          lb_we;
  logic                          accept;
  logic                          consume;

  assign in_s    = in;
  assign lb_addr = ADDR_W'(col_q >> 1);

  maxpool_line_buffer #(
    .data_width (data_width),
    .depth      (LB_DEPTH),
    .addr_w     (ADDR_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (lb_addr),
    .wr_data (hmax),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    lb_we       = 1'b0;

    // Single output register: a consumed slot can be refilled in the same cycle.
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    consume  = out_valid_q && out_ready;
    hmax     = smax(pair_q, in_s);
    pooled   = smax(lb_rd, hmax);

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (!col_q[0]) begin
        pair_d = in_s;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        // A result produced while the old one is consumed overrides the clear above.
        out_d       = pooled;
        out_valid_d = 1'b1;
        out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    frame_done = consume && out_last_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       iv4, ir4, ov4, or4, fd4;
  logic [7:0] in4, out4;
  logic       iv8, ir8, ov8, or8, fd8;
  logic [7:0] in8, out8;
  bit         rand_rdy8;

  maxpool2x2_stream #(.data_width(8), .img_width(4), .img_height(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .in(in4),
    .out_valid(ov4), .out_ready(or4), .out(out4), .frame_done(fd4)
  );

  maxpool2x2_stream #(.data_width(8), .img_width(8), .img_height(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in(in8),
    .out_valid(ov8), .out_ready(or8), .out(out8), .frame_done(fd8)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: pooled windows computed straight from the frame.
  int pix [64];
  int exp_v4 [$];
  bit exp_l4 [$];
  int exp_v8 [$];
  bit exp_l8 [$];
  int got4 [$];
  int got8 [$];
  int fdc4 = 0;
  int fdc8 = 0;

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model(input int k, input int w, input int h);
    int m;
    bit last;
    for (int r = 0; r < h; r += 2) begin
      for (int c = 0; c < w; c += 2) begin
        m = mx(mx(pix[r*w+c], pix[r*w+c+1]), mx(pix[(r+1)*w+c], pix[(r+1)*w+c+1]));
        last = (r == h - 2) && (c == w - 2);
        if (k == 0) begin exp_v4.push_back(m); exp_l4.push_back(last); end
        else begin exp_v8.push_back(m); exp_l8.push_back(last); end
      end
    end
  endtask

  // Scoreboards and hold-under-backpressure checks, sampled on the falling edge.
  bit         stall4, stall8;
  logic [7:0] hold4, hold8;

  always @(negedge clk) begin
    if (reset) begin
      stall4 = 1'b0;
    end else begin
      if (stall4) begin
        check("hold_valid4", ov4, 1);
        check("hold_data4", $signed(out4), $signed(hold4));
      end
      if (ov4 && or4) begin
        got4.push_back(int'($signed(out4)));
        if (exp_v4.size() == 0) check("spurious4", exp_v4.size(), 1);
        else begin
          check("out4", $signed(out4), exp_v4.pop_front());
          check("frame_done4", fd4, exp_l4.pop_front());
        end
        if (fd4) fdc4++;
      end
      stall4 = ov4 && !or4;
      hold4  = out4;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      stall8 = 1'b0;
    end else begin
      if (stall8) begin
        check("hold_valid8", ov8, 1);
        check("hold_data8", $signed(out8), $signed(hold8));
      end
      if (ov8 && or8) begin
        got8.push_back(int'($signed(out8)));
        if (exp_v8.size() == 0) check("spurious8", exp_v8.size(), 1);
        else begin
          check("out8", $signed(out8), exp_v8.pop_front());
          check("frame_done8", fd8, exp_l8.pop_front());
        end
        if (fd8) fdc8++;
      end
      stall8 = ov8 && !or8;
      hold8  = out8;
    end
  end

  always @(posedge clk) begin
    #1;
    or8 = rand_rdy8 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Returns 1 ns after the edge that accepted the sample.
  task automatic send(input int k, input int v, input bit gaps);
    int  n;
    bit  rdy;
    if (gaps) begin
      n = $urandom_range(0, 2);
      if (k == 0) iv4 = 1'b0; else iv8 = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
    end
    if (k == 0) begin iv4 = 1'b1; in4 = 8'(v); end
    else begin iv8 = 1'b1; in8 = 8'(v); end
    rdy = 1'b0;
    for (int t = 0; t < 200 && !rdy; t++) begin
      @(negedge clk);
      rdy = (k == 0) ? ir4 : ir8;
      @(posedge clk);
      #1;
    end
    if (!rdy) check("send_timeout", rdy, 1);
  endtask

  task automatic drain(input int k);
    int t = 0;
    while (((k == 0) ? exp_v4.size() : exp_v8.size()) != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check((k == 0) ? "drain4" : "drain8", (k == 0) ? exp_v4.size() : exp_v8.size(), 0);
  endtask

  int ref4 [4] = '{6, 8, 14, 16};
  int fd_base;

  initial begin
    reset = 1'b1;
    iv4 = 1'b0; in4 = '0; or4 = 1'b1;
    iv8 = 1'b0; in8 = '0;
    rand_rdy8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", ir4, 1);
    check("rst_out_valid", ov4, 0);
    check("rst_out", $signed(out4), 0);
    check("rst_frame_done", fd4, 0);
    reset = 1'b0;

    // 1..16 row-major, consumer always ready, latency checked per sample
    for (int i = 0; i < 16; i++) pix[i] = i + 1;
    model(0, 4, 4);
    got4.delete();
    fd_base = fdc4;
    for (int i = 0; i < 16; i++) begin
      send(0, pix[i], 1'b0);
      check("latency", ov4, ((i / 4) % 2 == 1) && (i % 2 == 1));
    end
    iv4 = 1'b0;
    drain(0);
    for (int j = 0; j < 4; j++) check("basic_out", got4[j], ref4[j]);
    check("basic_fd_count", fdc4 - fd_base, 1);

    // signed windows
    pix[0] = -5;  pix[1] = -3;  pix[2] = -128; pix[3] = 127;
    pix[4] = -8;  pix[5] = -1;  pix[6] = 0;    pix[7] = 0;
    for (int i = 8; i < 16; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
    model(0, 4, 4);
    got4.delete();
    for (int i = 0; i < 16; i++) send(0, pix[i], 1'b0);
    iv4 = 1'b0;
    drain(0);
    check("signed_neg", got4[0], -1);
    check("signed_ext", got4[1], 127);

    // backpressure after the first result
    for (int i = 0; i < 16; i++) pix[i] = i + 1;
    model(0, 4, 4);
    got4.delete();
    fork
      begin
        for (int i = 0; i < 16; i++) send(0, pix[i], 1'b0);
        iv4 = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (!ov4 && t < 100) begin @(posedge clk); #1; t++; end
        or4 = 1'b0;
        check("bp_seen", ov4, 1);
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", ir4, 0);
          check("bp_hold", $signed(out4), 6);
        end
        @(posedge clk);
        #1;
        or4 = 1'b1;
      end
    join
    drain(0);
    check("bp_count", got4.size(), 4);
    for (int j = 0; j < 4; j++) check("bp_out", got4[j], ref4[j]);

    // two back-to-back frames
    model(0, 4, 4);
    model(0, 4, 4);
    got4.delete();
    fd_base = fdc4;
    for (int i = 0; i < 32; i++) send(0, pix[i % 16], 1'b0);
    iv4 = 1'b0;
    drain(0);
    check("b2b_count", got4.size(), 8);
    check("b2b_fd_count", fdc4 - fd_base, 2);
    for (int j = 0; j < 8; j++) check("b2b_out", got4[j], ref4[j % 4]);

    // reset in the middle of a frame
    for (int i = 0; i < 6; i++) send(0, int'($urandom_range(0, 255)) - 128, 1'b0);
    iv4 = 1'b0;
    reset = 1'b1;
    #2;
    check("midrst_out_valid", ov4, 0);
    check("midrst_in_ready", ir4, 1);
    check("midrst_out", $signed(out4), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
    model(0, 4, 4);
    got4.delete();
    fd_base = fdc4;
    for (int i = 0; i < 16; i++) send(0, pix[i], 1'b0);
    iv4 = 1'b0;
    drain(0);
    check("midrst_count", got4.size(), 4);
    check("midrst_fd_count", fdc4 - fd_base, 1);

    // 8x8 random frame, random input gaps and random consumer stalls
    for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
    model(1, 8, 8);
    got8.delete();
    rand_rdy8 = 1'b1;
    for (int i = 0; i < 64; i++) send(1, pix[i], 1'b1);
    iv8 = 1'b0;
    drain(1);
    rand_rdy8 = 1'b0;
    check("rand_count", got8.size(), 16);
    check("rand_fd_count", fdc8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Streaming 2×2 / stride-2 max-pooling stage that sits directly downstream of the ReLU array lane. It accepts one signed activation per cycle in row-major order for an `img_width × img_height` feature map. It emits one pooled value per 2×2 window, also in row-major order. A half-row line buffer holds the horizontal pair maxima of even rows, so no full frame is ever stored.

## Interface
Parameters:
- `data_width`, 8: activation width, signed two's complement.
- `img_width`, 8: input columns per row; must be even and ≥2.
- `img_height`, 8: input rows per frame; must be even and ≥2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: input sample present.
- `in_ready`, output, 1: stage can accept a sample.
- `in`, input, `data_width`: signed activation.
- `out_valid`, output, 1: pooled result present.
- `out_ready`, input, 1: consumer accepts the result.
- `out`, output, `data_width`: signed pooled maximum.
- `frame_done`, output, 1: one-cycle pulse when the last output of a frame is accepted.

## Operation
- A sample is accepted when `in_valid && in_ready`. An output is consumed when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and gives a single output register with pass-through on consume.
- Counters track the position of the next accepted sample:
  - `col`: 0..`img_width`-1.
  - `row`: 0..`img_height`-1.
  - At `col` = `img_width`-1, `col` wraps to 0 and `row` increments. At the last row it also wraps to 0.
- Even column (col[0]=0): the sample is latched into `pair_reg`.
- Odd column: `hmax = max(pair_reg, in)`, using a signed comparison.
  - Even row: write `hmax` to line buffer entry `col>>1`.
  - Odd row: `out <= max(linebuf[col>>1], hmax)` and set `out_valid`.
- Ties return the common value. Comparisons are signed, so negative inputs (ReLU disabled) pool correctly.
- `out_valid` clears when the output is consumed and no new result is produced in the same cycle. If a new result is produced on the cycle of consumption, `out_valid` stays 1 and `out` updates.
- `frame_done` pulses when the accepted output corresponds to input `row`=`img_height`-1, `col`=`img_width`-1.
- There is no frame-start input. Frame alignment comes only from reset and the counter wrap. Back-to-back frames stream without bubbles.

## Timing
- Reset values:
  - `out_valid`=0, `out`=0, `frame_done`=0.
  - `col`=0, `row`=0, `pair_reg`=0.
  - `in_ready`=1 after reset.
- Line buffer contents are not reset. Each entry is always written on the even row before it is read on the odd row.
- Latency: `out_valid` rises the cycle after the accepted odd-row, odd-column sample.
- Throughput: 1 sample/cycle while `out_ready` is held high. An output occurs on at most 1 cycle in 4 accepted samples on average, so there is no steady-state stall.
- Backpressure:
  - If `out_valid && !out_ready`, then `in_ready`=0. Counters, `pair_reg` and the line buffer hold.
  - `out` and `out_valid` stay stable until the output is consumed.
- Reset asserted mid-frame: all counters and outputs return to reset values immediately (asynchronously). The first sample after reset is treated as row 0, col 0, and a partially pooled frame is discarded.
- `in_valid` low: nothing advances, with no effect on alignment.

## Structure
- Shared package `cnn_pkg` holds:
  - Default `data_width`.
  - Signed `max2` function.
  - Counter-width helper: `$clog2`-based localparams for `col` and `row` widths.
- Sub-module `maxpool_line_buffer`: depth `img_width/2`, width `data_width`, one write port and one asynchronous-read port indexed by `col>>1`. It is inferable as distributed RAM.
- The top holds the counters, `pair_reg`, the compare logic, the output register and the handshake.

## Test plan
- 4×4 frame with values 1..16 row-major, `out_ready`=1: outputs 6, 8, 14, 16 in order. `frame_done` pulses with 16. Each `out_valid` occurs one cycle after the sample that completes its window.
- Signed input: window {-5, -3, -8, -1} → -1. Window {-128, 127, 0, 0} → 127.
- Backpressure: `out_ready`=0 for 5 cycles after the first result. `in_ready` drops, `out` holds 6, and no samples are lost. The remaining outputs match the first case.
- Two back-to-back 4×4 frames with no idle cycles: 8 outputs and two `frame_done` pulses, with the second frame results identical to the first.
- Assert `reset` after 6 samples, then send a fresh 4×4 frame: only the fresh frame's 4 results appear, with none from the aborted frame.
- Random `in_valid` gaps combined with random `out_ready` over an 8×8 frame: the scoreboard matches a reference 2×2 max for all 16 outputs.
